symbol_normalizer: RTL

- Sits directly downstream of the FFT demodulator and consumes its per-subcarrier stream.
- Inputs: complex subcarriers, per-symbol metadata {sfn, subframe, symbol, blk_exp, pbch_flag}, and tlast on the last BWP subcarrier.
- Rescales every symbol to a common exponent TARGET_EXP using shift and saturate, so channel estimation and equalization see consistent scaling across symbols.
- Checks subcarrier framing and buffers output in a small FIFO. The FFT side has no backpressure, so the FIFO absorbs downstream stalls.

---
 rtl/symbol_normalizer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/symbol_normalizer.sv
// Rescales FFT output symbols to a common exponent, checks subcarrier framing and buffers in a FIFO.
// Build option: define SYMBOL_NORMALIZER_ROUND_EN to round right shifts half-up instead of truncating.

module symbol_normalizer_scale #(
    parameter int IH   = 8,
    parameter int OH   = 8,
    parameter int SH_W = 9
) (
    input  logic signed [IH-1:0]   x,
    input  logic signed [SH_W-1:0] sh,
    output logic signed [OH-1:0]   y
);
    localparam int WW = 2*OH + 2;
    localparam logic signed [WW-1:0]   SAT_MAX = WW'((64'sd1 <<< (OH-1)) - 64'sd1);
    localparam logic signed [WW-1:0]   SAT_MIN = ~SAT_MAX;
    localparam logic signed [SH_W-1:0] OH_S    = SH_W'(OH);
    localparam logic [SH_W-1:0]        IH_U    = SH_W'(IH);

    logic signed [WW-1:0] xw;
    logic signed [WW-1:0] acc;
    logic [SH_W-1:0]      rn;

    always_comb begin
        xw  = {{(WW-IH){x[IH-1]}}, x};
        acc = xw;
        rn  = '0;
        if (sh >= OH_S) begin
            acc = (x == '0) ? '0 : (x[IH-1] ? SAT_MIN : SAT_MAX);
        end else if (!sh[SH_W-1] && sh != '0) begin
            acc = xw <<< sh;
        end else if (sh[SH_W-1]) begin
            // Beyond IH bits every input has already collapsed to its sign (or 0 when rounding).
            rn = -sh;
            if (rn > IH_U)
                rn = IH_U;
`ifdef SYMBOL_NORMALIZER_ROUND_EN
            acc = (xw + (WW'(1) <<< (rn - SH_W'(1)))) >>> rn;
`else
            acc = xw >>> rn;
`endif
        end
        if (acc > SAT_MAX)
            y = SAT_MAX[OH-1:0];
        else if (acc < SAT_MIN)
            y = SAT_MIN[OH-1:0];
        else
            y = acc[OH-1:0];
    end
endmodule

module symbol_normalizer #(
    parameter int IN_DW                 = 16,
    parameter int OUT_DW                = 16,
    parameter int BLK_EXP_LEN           = 8,
    parameter int TARGET_EXP            = 0,
    parameter int BWP_LEN               = 240,
    parameter int SFN_WIDTH             = 10,
    parameter int SUBFRAME_NUMBER_WIDTH = 5,
    parameter int SYMBOL_NUMBER_WIDTH   = 4,
    parameter int FIFO_LEN              = 16
) (
    input  logic                                                                       clk_i,
    input  logic                                                                       reset_i,
    input  logic [IN_DW-1:0]                                                           s_axis_in_tdata,
    input  logic [SFN_WIDTH+SUBFRAME_NUMBER_WIDTH+SYMBOL_NUMBER_WIDTH+BLK_EXP_LEN:0]   s_axis_in_tuser,
    input  logic                                                                       s_axis_in_tlast,
    input  logic                                                                       s_axis_in_tvalid,
    output logic [OUT_DW-1:0]                                                          m_axis_out_tdata,
    output logic [SFN_WIDTH+SUBFRAME_NUMBER_WIDTH+SYMBOL_NUMBER_WIDTH:0]               m_axis_out_tuser,
    output logic [$clog2(BWP_LEN)-1:0]                                                 m_axis_out_sc_idx,
    output logic                                                                       m_axis_out_tlast,
    output logic                                                                       m_axis_out_tvalid,
    input  logic                                                                       m_axis_out_tready,
    output logic                                                                       framing_err_o,
    output logic                                                                       overflow_o
);
    localparam int IH    = IN_DW / 2;
    localparam int OH    = OUT_DW / 2;
    localparam int SH_W  = BLK_EXP_LEN + 1;
    localparam int TUW   = SFN_WIDTH + SUBFRAME_NUMBER_WIDTH + SYMBOL_NUMBER_WIDTH + BLK_EXP_LEN + 1;
    localparam int MW    = TUW - BLK_EXP_LEN;
    localparam int IDXW  = $clog2(BWP_LEN);
    localparam int PW    = $clog2(FIFO_LEN);
    localparam logic [IDXW-1:0] LAST_SC = IDXW'(BWP_LEN - 1);
    localparam logic [PW:0]     CAP     = (PW+1)'(FIFO_LEN);

    typedef struct packed {
        logic [1:0][OH-1:0] data;
        logic [MW-1:0]      meta;
        logic [IDXW-1:0]    idx;
        logic               last;
    } entry_t;

    // Stage 1: input register, subcarrier counter, per-symbol metadata latch
    logic [IDXW-1:0]        sc_cnt;
    logic                   at_last;
    logic                   s1_vld;
    logic                   s1_err;
    logic [1:0][IH-1:0]     s1_cmp;
    logic signed [SH_W-1:0] s1_shift;
    logic [MW-1:0]          s1_meta;
    logic [IDXW-1:0]        s1_idx;
    logic                   s1_last;

    assign at_last = (sc_cnt == LAST_SC);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sc_cnt   <= '0;
            s1_vld   <= 1'b0;
            s1_err   <= 1'b0;
            s1_cmp   <= '0;
            s1_shift <= '0;
            s1_meta  <= '0;
            s1_idx   <= '0;
            s1_last  <= 1'b0;
        end else begin
            s1_vld <= s_axis_in_tvalid;
            s1_err <= s_axis_in_tvalid && (s_axis_in_tlast != at_last);
            if (s_axis_in_tvalid) begin
                s1_cmp  <= s_axis_in_tdata;
                s1_idx  <= sc_cnt;
                s1_last <= at_last;
                sc_cnt  <= (s_axis_in_tlast || at_last) ? '0 : sc_cnt + IDXW'(1);
                // Metadata and shift are held for the whole symbol; later tuser values are ignored.
                if (sc_cnt == '0) begin
                    s1_meta  <= {s_axis_in_tuser[TUW-1:BLK_EXP_LEN+1], s_axis_in_tuser[0]};
                    s1_shift <= $signed({1'b0, s_axis_in_tuser[BLK_EXP_LEN:1]}) - SH_W'(TARGET_EXP);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            framing_err_o <= 1'b0;
        else
            framing_err_o <= s1_err;
    end

    // Stage 2: per-component shift/saturate feeding the FIFO write
    logic [1:0][OH-1:0] s2_cmp;

    for (genvar c = 0; c < 2; c++) begin : g_cmp
        symbol_normalizer_scale #(.IH(IH), .OH(OH), .SH_W(SH_W)) u_scale (
            .x  (s1_cmp[c]),
            .sh (s1_shift),
            .y  (s2_cmp[c])
        );
    end

    entry_t wr_entry;
    assign wr_entry = '{data: s2_cmp, meta: s1_meta, idx: s1_idx, last: s1_last};

    // Output FIFO; the output register counts toward capacity so FIFO_LEN beats total are held.
    entry_t          mem [FIFO_LEN];
    entry_t          rd_entry;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     mem_cnt;
    logic            full;
    logic            load;
    logic            wr_ok;

    assign rd_entry = mem[rd_ptr];
    assign full     = (mem_cnt + {{PW{1'b0}}, m_axis_out_tvalid}) == CAP;
    assign load     = (mem_cnt != '0) && (!m_axis_out_tvalid || m_axis_out_tready);
    assign wr_ok    = s1_vld && (!full || (m_axis_out_tvalid && m_axis_out_tready));

    always_ff @(posedge clk_i) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            mem_cnt           <= '0;
            overflow_o        <= 1'b0;
            m_axis_out_tdata  <= '0;
            m_axis_out_tuser  <= '0;
            m_axis_out_sc_idx <= '0;
            m_axis_out_tlast  <= 1'b0;
            m_axis_out_tvalid <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (load)
                rd_ptr <= rd_ptr + PW'(1);
            mem_cnt <= mem_cnt + (PW+1)'(wr_ok) - (PW+1)'(load);
            if (s1_vld && !wr_ok)
                overflow_o <= 1'b1;
            if (load) begin
                m_axis_out_tdata  <= rd_entry.data;
                m_axis_out_tuser  <= rd_entry.meta;
                m_axis_out_sc_idx <= rd_entry.idx;
                m_axis_out_tlast  <= rd_entry.last;
                m_axis_out_tvalid <= 1'b1;
            end else if (m_axis_out_tready) begin
                m_axis_out_tvalid <= 1'b0;
            end
        end
    end
endmodule
